// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory request arbiter: FSM states, grant owner
// codes and transfer size constants.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GRANT_IF = 3'd1,
    GRANT_LD = 3'd2,
    GRANT_ST = 3'd3,
    RESP     = 3'd4
  } arb_state_e;

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_IF   = 2'd1;
  localparam logic [1:0] SRC_LD   = 2'd2;
  localparam logic [1:0] SRC_ST   = 2'd3;

  localparam logic [2:0] SZ_B = 3'd1;
  localparam logic [2:0] SZ_H = 3'd2;
  localparam logic [2:0] SZ_W = 3'd4;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of arbitrations fetch has lost; raises force_if once the
// limit is reached so the next idle decision goes to fetch.
module mem_arb_starve_ctr #(
  parameter int LIMIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  input  logic inc,
  input  logic clr,
  output logic force_if
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(LIMIT);

  logic [CW-1:0] cnt;

  // Lost-arbitration counter, held while rdy is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (rdy) begin
      if (clr) begin
        cnt <= '0;
      end else if (inc && (cnt != LIM)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign force_if = (cnt == LIM);

endmodule

// File: rtl/mem_req_arbiter.sv
// Arbitrates fetch/load/store onto one byte-serial memory controller.
// Optional fetch anti-starvation is enabled with MEM_ARB_STARVE_EN.
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              jump_rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [2:0]        ld_size,
  output logic              ld_done,
  output logic [31:0]       ld_data,
  input  logic              st_req,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [2:0]        st_size,
  input  logic [31:0]       st_data,
  output logic              st_done,
  output logic              mc_valid,
  output logic              mc_wr,
  output logic [ADDR_W-1:0] mc_addr,
  output logic [2:0]        mc_size,
  output logic [31:0]       mc_wdata,
  output logic              mc_abort,
  input  logic              mc_done,
  input  logic [31:0]       mc_rdata,
  output logic [1:0]        grant_src
);

  arb_state_e  state, state_nx;
  logic [1:0]  win;
  logic [1:0]  resp_src;
  logic [31:0] resp_data;
  logic        abort_go;
  logic        force_if;

`ifdef MEM_ARB_STARVE_EN
  logic starve_inc;
  logic starve_clr;

  assign starve_inc = (state == IDLE) && if_req && ((win == SRC_LD) || (win == SRC_ST));
  assign starve_clr = jump_rst || ((state == IDLE) && (win == SRC_IF));

  mem_arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .inc      (starve_inc),
    .clr      (starve_clr),
    .force_if (force_if)
  );
`else
  // A negative limit is meaningless, so this is the fixed-priority build.
  assign force_if = (STARVE_LIMIT < 0);
`endif

  // Arbitration decision and next-state selection
  always_comb begin
    state_nx = state;
    win      = SRC_NONE;
    abort_go = 1'b0;
    case (state)
      IDLE: begin
        // A flush blocks speculative winners but never a committed store.
        if (force_if && if_req && !jump_rst) begin
          win = SRC_IF;
        end else if (st_req) begin
          win = SRC_ST;
        end else if (ld_req && !jump_rst) begin
          win = SRC_LD;
        end else if (if_req && !jump_rst) begin
          win = SRC_IF;
        end else begin
          win = SRC_NONE;
        end
        case (win)
          SRC_IF:  state_nx = GRANT_IF;
          SRC_LD:  state_nx = GRANT_LD;
          SRC_ST:  state_nx = GRANT_ST;
          default: state_nx = IDLE;
        endcase
      end
      GRANT_IF, GRANT_LD: begin
        if (jump_rst) begin
          abort_go = 1'b1;
          state_nx = IDLE;
        end else if (mc_done) begin
          state_nx = RESP;
        end else begin
          state_nx = state;
        end
      end
      GRANT_ST: begin
        if (mc_done) begin
          state_nx = RESP;
        end else begin
          state_nx = state;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else if (rdy) begin
      state <= state_nx;
    end
  end

  // Registered controller request, grant owner and response steering
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mc_valid  <= 1'b0;
      mc_wr     <= 1'b0;
      mc_addr   <= '0;
      mc_size   <= 3'd0;
      mc_wdata  <= 32'h0;
      mc_abort  <= 1'b0;
      grant_src <= SRC_NONE;
      if_done   <= 1'b0;
      if_data   <= 32'h0;
      ld_done   <= 1'b0;
      ld_data   <= 32'h0;
      st_done   <= 1'b0;
      resp_src  <= SRC_NONE;
      resp_data <= 32'h0;
    end else if (rdy) begin
      mc_abort <= 1'b0;
      if_done  <= 1'b0;
      ld_done  <= 1'b0;
      st_done  <= 1'b0;
      case (state)
        IDLE: begin
          case (win)
            SRC_IF: begin
              mc_addr  <= if_addr;
              mc_size  <= SZ_W;
              mc_wdata <= 32'h0;
            end
            SRC_LD: begin
              mc_addr  <= ld_addr;
              mc_size  <= ld_size;
              mc_wdata <= 32'h0;
            end
            SRC_ST: begin
              mc_addr  <= st_addr;
              mc_size  <= st_size;
              mc_wdata <= st_data;
            end
            default: ;
          endcase
          mc_valid  <= (win != SRC_NONE);
          mc_wr     <= (win == SRC_ST);
          grant_src <= win;
        end
        GRANT_IF, GRANT_LD, GRANT_ST: begin
          if (abort_go) begin
            mc_valid  <= 1'b0;
            mc_wr     <= 1'b0;
            mc_abort  <= 1'b1;
            grant_src <= SRC_NONE;
          end else if (mc_done) begin
            mc_valid  <= 1'b0;
            mc_wr     <= 1'b0;
            grant_src <= SRC_NONE;
            resp_src  <= grant_src;
            resp_data <= mc_rdata;
          end
        end
        RESP: begin
          if (!(jump_rst && (resp_src != SRC_ST))) begin
            case (resp_src)
              SRC_IF: begin
                if_done <= 1'b1;
                if_data <= resp_data;
              end
              SRC_LD: begin
                ld_done <= 1'b1;
                ld_data <= resp_data;
              end
              SRC_ST:  st_done <= 1'b1;
              default: ;
            endcase
          end
        end
        default: begin
          mc_valid  <= 1'b0;
          mc_wr     <= 1'b0;
          grant_src <= SRC_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed, table-driven bench for mem_req_arbiter plus hand-written
// sequences for flush, freeze, starvation and asynchronous reset.
module tb_mem_req_arbiter;

  logic        clk = 1'b0;
  logic        rst, rdy, jump_rst;
  logic        if_req, if_done;
  logic [31:0] if_addr, if_data;
  logic        ld_req, ld_done;
  logic [31:0] ld_addr, ld_data;
  logic [2:0]  ld_size;
  logic        st_req, st_done;
  logic [31:0] st_addr, st_data;
  logic [2:0]  st_size;
  logic        mc_valid, mc_wr, mc_abort, mc_done;
  logic [31:0] mc_addr, mc_wdata, mc_rdata;
  logic [2:0]  mc_size;
  logic [1:0]  grant_src;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]  src;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
    logic        exp_wr;
    logic [2:0]  exp_size;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [6];

  mem_req_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy), .jump_rst(jump_rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_size(ld_size), .ld_done(ld_done), .ld_data(ld_data),
    .st_req(st_req), .st_addr(st_addr), .st_size(st_size), .st_data(st_data), .st_done(st_done),
    .mc_valid(mc_valid), .mc_wr(mc_wr), .mc_addr(mc_addr), .mc_size(mc_size),
    .mc_wdata(mc_wdata), .mc_abort(mc_abort), .mc_done(mc_done), .mc_rdata(mc_rdata),
    .grant_src(grant_src)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] done_of(input logic [1:0] src);
    case (src)
      2'd1:    return 3'b100;
      2'd2:    return 3'b010;
      2'd3:    return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  task automatic drive_req(input vec_t v);
    case (v.src)
      2'd1: begin if_req = 1'b1; if_addr = v.addr; end
      2'd2: begin ld_req = 1'b1; ld_addr = v.addr; ld_size = v.size; end
      2'd3: begin st_req = 1'b1; st_addr = v.addr; st_size = v.size; st_data = v.wdata; end
      default: ;
    endcase
  endtask

  task automatic drop_reqs();
    if_req = 1'b0;
    ld_req = 1'b0;
    st_req = 1'b0;
  endtask

  // Finish the current grant: mc_done, RESP, then the done pulse.
  task automatic complete(input string name, input logic [1:0] src, input logic [31:0] rdata);
    mc_done = 1'b1; mc_rdata = rdata;
    tick();
    mc_done = 1'b0; mc_rdata = 32'h0;
    chk({name, "_resp_valid"}, mc_valid, 1'b0);
    chk({name, "_resp_nodone"}, {if_done, ld_done, st_done}, 3'b000);
    tick();
    chk({name, "_done"}, {if_done, ld_done, st_done}, done_of(src));
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; jump_rst = 1'b0;
    if_req = 1'b0; if_addr = 32'h0;
    ld_req = 1'b0; ld_addr = 32'h0; ld_size = 3'd0;
    st_req = 1'b0; st_addr = 32'h0; st_size = 3'd0; st_data = 32'h0;
    mc_done = 1'b0; mc_rdata = 32'h0;

    vecs[0] = '{2'd1, 32'h0000_1000, 3'd0, 32'h0,         32'hDEAD_BEEF, 4, 1'b0, 3'd4, 32'hDEAD_BEEF};
    vecs[1] = '{2'd2, 32'h0000_0044, 3'd1, 32'h0,         32'h0000_00A5, 2, 1'b0, 3'd1, 32'h0000_00A5};
    vecs[2] = '{2'd2, 32'h0000_0048, 3'd2, 32'h0,         32'h0000_BEEF, 3, 1'b0, 3'd2, 32'h0000_BEEF};
    vecs[3] = '{2'd3, 32'h0000_0020, 3'd2, 32'h0000_1234, 32'h0,         3, 1'b1, 3'd2, 32'h0000_1234};
    vecs[4] = '{2'd3, 32'h0000_0080, 3'd5, 32'hCAFE_F00D, 32'h0,         2, 1'b1, 3'd5, 32'hCAFE_F00D};
    vecs[5] = '{2'd2, 32'h0000_0100, 3'd4, 32'h0,         32'h1234_5678, 2, 1'b0, 3'd4, 32'h1234_5678};

    #12;
    chk("rst_valid", mc_valid, 1'b0);
    chk("rst_grant", grant_src, 2'd0);
    chk("rst_outs", {if_done, ld_done, st_done, mc_abort, mc_wr}, 5'b0);
    chk("rst_addr", mc_addr, 32'h0);
    rst = 1'b0;
    tick();

    // Table: single-requester transactions
    for (int i = 0; i < 6; i++) begin
      drive_req(vecs[i]);
      tick();
      chk("grant_valid", mc_valid, 1'b1);
      chk("grant_src", grant_src, vecs[i].src);
      chk("grant_addr", mc_addr, vecs[i].addr);
      chk("grant_size", mc_size, vecs[i].exp_size);
      chk("grant_wr", mc_wr, vecs[i].exp_wr);
      if (vecs[i].exp_wr) chk("grant_wdata", mc_wdata, vecs[i].exp_data);
      if_addr = ~if_addr; ld_addr = ~ld_addr; st_addr = ~st_addr;
      st_data = ~st_data; ld_size = 3'd7; st_size = 3'd7;
      for (int k = 1; k < vecs[i].lat; k++) tick();
      chk("hold_addr", mc_addr, vecs[i].addr);
      chk("hold_size", mc_size, vecs[i].exp_size);
      complete("vec", vecs[i].src, vecs[i].rdata);
      if (vecs[i].src == 2'd1) chk("if_data", if_data, vecs[i].exp_data);
      if (vecs[i].src == 2'd2) chk("ld_data", ld_data, vecs[i].exp_data);
      drop_reqs();
      tick();
      chk("post_done", {if_done, ld_done, st_done}, 3'b000);
      chk("post_valid", mc_valid, 1'b0);
    end

    // Store beats simultaneous load; load follows two cycles after mc_done
    st_req = 1'b1; st_addr = 32'h20; st_size = 3'd2; st_data = 32'h1234;
    ld_req = 1'b1; ld_addr = 32'h30; ld_size = 3'd4;
    tick();
    chk("prio_src", grant_src, 2'd3);
    chk("prio_wr", mc_wr, 1'b1);
    chk("prio_wdata", mc_wdata, 32'h1234);
    chk("prio_size", mc_size, 3'd2);
    complete("prio_st", 2'd3, 32'h0);
    st_req = 1'b0;
    chk("prio_gap", mc_valid, 1'b0);
    tick();
    chk("prio_ld_src", grant_src, 2'd2);
    chk("prio_ld_addr", mc_addr, 32'h30);
    complete("prio_ld", 2'd2, 32'h77);
    chk("prio_ld_data", ld_data, 32'h77);
    drop_reqs();
    tick();

    // Flush during load grant, with a coincident mc_done
    ld_req = 1'b1; ld_addr = 32'h200; ld_size = 3'd4;
    tick();
    chk("jld_src", grant_src, 2'd2);
    jump_rst = 1'b1; mc_done = 1'b1; mc_rdata = 32'h99;
    tick();
    jump_rst = 1'b0; mc_done = 1'b0; ld_req = 1'b0;
    chk("jld_abort", mc_abort, 1'b1);
    chk("jld_valid", mc_valid, 1'b0);
    chk("jld_src0", grant_src, 2'd0);
    tick();
    chk("jld_abort_end", mc_abort, 1'b0);
    chk("jld_nodone", ld_done, 1'b0);
    tick();
    chk("jld_nodone2", ld_done, 1'b0);

    // Flush during store grant is ignored
    st_req = 1'b1; st_addr = 32'h300; st_size = 3'd1; st_data = 32'hAB;
    tick();
    jump_rst = 1'b1;
    tick();
    jump_rst = 1'b0;
    chk("jst_abort", mc_abort, 1'b0);
    chk("jst_src", grant_src, 2'd3);
    complete("jst", 2'd3, 32'h0);
    drop_reqs();
    tick();

    // Flush in RESP suppresses the fetch response
    if_req = 1'b1; if_addr = 32'h400;
    tick();
    mc_done = 1'b1; mc_rdata = 32'h5555;
    tick();
    mc_done = 1'b0; jump_rst = 1'b1; if_req = 1'b0;
    tick();
    jump_rst = 1'b0;
    chk("jresp_nodone", if_done, 1'b0);
    chk("jresp_abort", mc_abort, 1'b0);
    tick();

    // Flush in IDLE: fetch/load blocked, store still granted
    if_req = 1'b1; ld_req = 1'b1; jump_rst = 1'b1;
    tick();
    chk("jidle_none", {mc_valid, grant_src}, 3'b000);
    st_req = 1'b1; st_addr = 32'h40; st_size = 3'd4; st_data = 32'h55;
    tick();
    jump_rst = 1'b0; if_req = 1'b0; ld_req = 1'b0;
    chk("jidle_st", grant_src, 2'd3);
    complete("jidle_st", 2'd3, 32'h0);
    drop_reqs();
    tick();

    // rdy low freezes an in-flight fetch
    if_req = 1'b1; if_addr = 32'h2000;
    tick();
    rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("frz_state", {mc_valid, grant_src, if_done}, 4'b1010);
      chk("frz_addr", mc_addr, 32'h2000);
    end
    rdy = 1'b1;
    complete("frz", 2'd1, 32'h0BAD_F00D);
    chk("frz_data", if_data, 32'h0BAD_F00D);
    drop_reqs();
    tick();

    // Asynchronous reset between edges during a fetch grant
    if_req = 1'b1; if_addr = 32'h3000;
    tick();
    chk("arst_pre", mc_valid, 1'b1);
    #3 rst = 1'b1;
    #1;
    chk("arst_valid", mc_valid, 1'b0);
    chk("arst_src", grant_src, 2'd0);
    if_req = 1'b0;
    #1 rst = 1'b0;
    tick();
    chk("arst_idle", mc_valid, 1'b0);

    // Continuous load stream with fetch pending
    if_req = 1'b1; if_addr = 32'h5000;
    ld_req = 1'b1; ld_addr = 32'h600; ld_size = 3'd4;
    for (int i = 0; i < 12; i++) begin
      logic [1:0] exp_src;
      exp_src = 2'd2;
`ifdef MEM_ARB_STARVE_EN
      if (i == 8) exp_src = 2'd1;
`endif
      tick();
      chk("starve_src", grant_src, exp_src);
      mc_done = 1'b1; mc_rdata = 32'h0;
      tick();
      mc_done = 1'b0;
      tick();
    end
    drop_reqs();
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Sits between the three memory requesters (instruction fetch, load path, store path) and the single byte-serial memory controller.
- Grants the controller to exactly one requester at a time and holds that grant until the transfer completes.
- Steers the read data and completion back to the granted requester.
- Cancels speculative traffic on a branch flush. Committed stores are never cancelled.

Parameters:
- ADDR_W, 32, address width of all address ports.
- STARVE_LIMIT, 8, consecutive lost arbitrations after which fetch is forced to win (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- rdy  in  1  global enable; when low, all state and outputs hold
- jump_rst  in  1  branch-mispredict flush
- if_req  in  1  fetch request, level, held until if_done
- if_addr  in  ADDR_W  fetch address (always 4-byte access)
- if_done  out  1  one-cycle completion pulse
- if_data  out  32  fetched word, valid with if_done
- ld_req  in  1  load request, level
- ld_addr  in  ADDR_W  load address
- ld_size  in  3  bytes to read: 1, 2 or 4
- ld_done  out  1  one-cycle completion pulse
- ld_data  out  32  zero-extended raw load data
- st_req  in  1  store request (committed), level
- st_addr  in  ADDR_W  store address
- st_size  in  3  bytes to write: 1, 2 or 4
- st_data  in  32  store data, little-endian
- st_done  out  1  one-cycle completion pulse
- mc_valid  out  1  request to memory controller
- mc_wr  out  1  1 = store, 0 = read
- mc_addr  out  ADDR_W  registered copy of the granted address
- mc_size  out  3  registered copy of the granted size
- mc_wdata  out  32  registered copy of the store data
- mc_abort  out  1  one-cycle pulse telling the controller to drop the current read
- mc_done  in  1  controller completion pulse
- mc_rdata  in  32  read data, valid with mc_done
- grant_src  out  2  current owner: 0 none, 1 fetch, 2 load, 3 store

Behaviour:
- Reset (asynchronous): state IDLE; all outputs 0; starvation counter 0.
- States:
  - IDLE: choose a winner among the active requests.
  - GRANT_IF, GRANT_LD, GRANT_ST: a transfer is in flight for that requester.
  - RESP: one-cycle return slot; always goes back to IDLE.
- Priority in IDLE: st_req > ld_req > if_req.
- On a win:
  - Latch address, size and data into the mc_* registers.
  - Set mc_valid = 1, mc_wr according to the winner, and grant_src.
  - Move to the matching GRANT state.
  - Latency: request seen at edge N gives mc_valid high after edge N.
- In GRANT_* the mc_* outputs stay stable and requester inputs are ignored. Changing a requester's inputs mid-grant has no effect.
- When mc_done is seen in GRANT_*:
  - mc_valid falls.
  - The matching *_done pulses on the next edge, together with the data (mc_rdata copied to if_data or ld_data).
  - State goes to RESP, then IDLE. A new grant therefore happens no earlier than 2 cycles after mc_done.
- Requesters drop *_req on the same edge that *_done rises. The RESP cycle guarantees a stale request is never re-granted.
- jump_rst in GRANT_IF or GRANT_LD:
  - mc_abort pulses, mc_valid falls.
  - State goes to IDLE. No *_done is issued.
  - A mc_done arriving in the same cycle is discarded.
- jump_rst in GRANT_ST: ignored. The store completes and st_done pulses normally.
- jump_rst in IDLE or RESP:
  - Pending fetch and load requests are not granted that cycle. A store may still be granted.
  - A RESP holding a fetch or load response is suppressed (no done pulse).
- rdy low: full freeze, including an in-flight grant. If mc_done arrives while rdy is low it is lost, so the controller must also be rdy-gated.
- Reset mid-transfer: immediate return to IDLE, mc_valid = 0.
- Invalid size (0, 3, 5–7): passed through unchanged. Checking is the requester's responsibility.

Optional Feature:
- Macro: MEM_ARB_STARVE_EN.
- When defined:
  - The counter increments each time IDLE grants load or store while if_req is high.
  - When the counter reaches STARVE_LIMIT, the next IDLE decision grants fetch regardless of other requests.
  - The counter clears on any fetch grant and on jump_rst.
- When undefined: strict fixed priority, no counter logic.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encoding (IDLE, GRANT_IF, GRANT_LD, GRANT_ST, RESP);
  - grant_src codes;
  - size constants SZ_B = 1, SZ_H = 2, SZ_W = 4.
- One sub-module: mem_arb_starve_ctr, the saturating counter plus force flag, instantiated only under MEM_ARB_STARVE_EN.
- All other logic stays in the top module.

Test Plan:
- Fetch only: if_req, if_addr = 0x1000; controller returns mc_rdata = 0xDEADBEEF, 4 cycles later -> mc_addr = 0x1000, mc_size = 4, mc_wr = 0; if_done with if_data = 0xDEADBEEF, 1 cycle after mc_done.
- Simultaneous st_req (addr 0x20, size 2, data 0x1234) and ld_req -> store granted first (mc_wr = 1, mc_wdata = 0x1234, mc_size = 2); load granted 2 cycles after the store's mc_done.
- jump_rst during GRANT_LD -> mc_abort pulse, no ld_done, grant_src = 0 the next cycle; jump_rst during GRANT_ST -> st_done still pulses.
- rdy low for 5 cycles mid-fetch -> all outputs unchanged; completion resumes correctly once rdy returns high.
- Starvation (MEM_ARB_STARVE_EN defined, STARVE_LIMIT = 8): if_req held while load requests arrive continuously -> fetch granted after 8 load grants; without the macro, fetch is never granted during the load stream.
- Async reset asserted mid-GRANT_IF, between clock edges -> mc_valid = 0 and grant_src = 0 immediately, with no clock edge needed.
